// File: rtl/q2_panel_pkg.sv
// Shared constants for the q2 front-panel driver: command op encodings, FSM
// state encodings and small decode helpers used by the driver and its bench.
package q2_panel_pkg;

   typedef enum logic [1:0] {
      OP_DEP   = 2'd0,
      OP_INCP  = 2'd1,
      OP_START = 2'd2,
      OP_STOP  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_PULSE    = 3'd2,
      ST_HOLD     = 3'd3,
      ST_WAIT_RUN = 3'd4,
      ST_RESP     = 3'd5
   } state_e;

   // One-hot switch select, bit order {stop, start, incp, dep}.
   function automatic logic [3:0] pulse_sel(input op_e op);
      return 4'b0001 << op;
   endfunction

   function automatic logic is_run_op(input op_e op);
      return (op == OP_START) || (op == OP_STOP);
   endfunction

endpackage

// File: rtl/q2_panel_timer.sv
// Loadable down-counter shared by every timed state of the panel driver;
// expired_o is high while the count sits at zero.
module q2_panel_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/q2_panel_driver.sv
// Front-panel sequencer: turns valid/ready commands into timed switch
// activity on the q2 panel inputs and confirms START/STOP via run.
module q2_panel_driver
   import q2_panel_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int PULSE_CYCLES  = 16,
   parameter int RUN_TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [11:0] cmd_data,
   input  logic        run,
   output logic [11:0] sw,
   output logic        dep_sw,
   output logic        incp_sw,
   output logic        start_sw,
   output logic        stop_sw,
   output logic        resp_valid,
   output logic        resp_err
);

   localparam int MAX_SP  = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
   localparam int MAX_CNT = (MAX_SP > RUN_TIMEOUT) ? MAX_SP : RUN_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   // Loading N-1 makes expired land on the Nth cycle of the state; the run
   // wait gets RUN_TIMEOUT cycles after its first (already-satisfied) check.
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LD    = CNT_W'(RUN_TIMEOUT);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [11:0]        sw_q, sw_d;
   logic               err_q, err_d;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic               tmr_expired;
   logic               run_ok;
   logic [3:0]         pulse;

   q2_panel_timer #(.W(CNT_W)) u_timer (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   assign run_ok = (op_q == OP_START) ? run : !run;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sw_d     = sw_q;
      err_d    = err_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_d = op_e'(cmd_op);
               if (op_e'(cmd_op) == OP_DEP) sw_d = cmd_data;
               err_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LD;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_expired) begin
               tmr_load = 1'b1;
               tmr_val  = PULSE_LD;
               state_d  = ST_PULSE;
            end
         end
         ST_PULSE: begin
            if (tmr_expired) begin
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LD;
               state_d  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_expired) begin
               if (is_run_op(op_q)) begin
                  tmr_load = 1'b1;
                  tmr_val  = RUN_LD;
                  state_d  = ST_WAIT_RUN;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WAIT_RUN: begin
            if (run_ok) begin
               state_d = ST_RESP;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_DEP;
         sw_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         sw_q    <= sw_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode straight from registered state so reset clears them at once.
   assign pulse      = (state_q == ST_PULSE) ? pulse_sel(op_q) : 4'b0000;
   assign dep_sw     = pulse[0];
   assign incp_sw    = pulse[1];
   assign start_sw   = pulse[2];
   assign stop_sw    = pulse[3];
   assign sw         = sw_q;
   assign cmd_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_q2_panel_driver.sv
// Directed bench for q2_panel_driver with S=4, P=3, RUN_TIMEOUT=20; responses
// are checked against a queue of expected (err, cycle) entries.
module tb_q2_panel_driver;
   import q2_panel_pkg::*;

   localparam int S = 4;
   localparam int P = 3;
   localparam int T = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [11:0] cmd_data;
   logic        run;
   logic [11:0] sw;
   logic        dep_sw, incp_sw, start_sw, stop_sw;
   logic        resp_valid, resp_err;

   typedef struct {
      logic err;
      int   cyc;
   } resp_t;

   resp_t       sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [11:0] exp_sw = 12'h000;

   q2_panel_driver #(
      .SETTLE_CYCLES (S),
      .PULSE_CYCLES  (P),
      .RUN_TIMEOUT   (T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .run        (run),
      .sw         (sw),
      .dep_sw     (dep_sw),
      .incp_sw    (incp_sw),
      .start_sw   (start_sw),
      .stop_sw    (stop_sw),
      .resp_valid (resp_valid),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_resp(input logic err, input int at_cyc);
      resp_t e;
      e.err = err;
      e.cyc = at_cyc;
      sb.push_back(e);
   endtask

   // Response monitor: every resp_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (rst && resp_valid) begin
         resp_t e;
         chk("resp_pending", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_err", resp_err, e.err);
            chk("resp_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic run_cmd(input op_e op, input logic [11:0] data, input int lat,
                          input logic err_exp, input int rise_at);
      int w;
      int cnt[4];
      int first[4];
      int last[4];
      int viol;
      int sw_bad;
      int others;
      logic [3:0] swv;
      w = 0;
      while (!cmd_ready && w < 200) begin
         step();
         w++;
      end
      chk("idle_before_cmd", cmd_ready, 1);
      cmd_op    = op;
      cmd_data  = data;
      cmd_valid = 1'b1;
      push_resp(err_exp, cyc + lat);
      if (op == OP_DEP) exp_sw = data;
      for (int i = 0; i < 4; i++) begin
         cnt[i] = 0; first[i] = 0; last[i] = 0;
      end
      viol = 0;
      sw_bad = 0;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k <= lat + 1; k++) begin
         swv = {stop_sw, start_sw, incp_sw, dep_sw};
         if ($countones(swv) > 1) viol++;
         if (sw !== exp_sw) sw_bad++;
         for (int i = 0; i < 4; i++) begin
            if (swv[i]) begin
               cnt[i]++;
               if (first[i] == 0) first[i] = k;
               last[i] = k;
            end
         end
         if (k == rise_at) run = 1'b1;
         if (k <= lat) step();
      end
      others = cnt[0] + cnt[1] + cnt[2] + cnt[3] - cnt[int'(op)];
      chk("pulse_first", first[int'(op)], S + 1);
      chk("pulse_last", last[int'(op)], S + P);
      chk("pulse_len", cnt[int'(op)], P);
      chk("other_switches", others, 0);
      chk("onehot", viol, 0);
      chk("sw_stable", sw_bad, 0);
      chk("ready_after_resp", cmd_ready, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      int acc;
      int nresp;
      rst       = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = OP_DEP;
      cmd_data  = 12'hA5C;
      run       = 1'b0;
      repeat (3) step();
      chk("rst_ready", cmd_ready, 1);
      chk("rst_sw", sw, 0);
      chk("rst_switches", {stop_sw, start_sw, incp_sw, dep_sw}, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);

      // DEP accepted on the first edge after release.
      rst = 1'b1;
      run_cmd(OP_DEP, 12'hA5C, 1 + 2*S + P, 1'b0, 0);
      chk("dep_sw_kept", sw, 12'hA5C);

      run_cmd(OP_INCP, 12'hFFF, 1 + 2*S + P, 1'b0, 0);
      chk("incp_sw_kept", sw, 12'hA5C);

      // run rises 10 cycles after the last start_sw cycle (cycle 7 -> 17).
      run_cmd(OP_START, 12'h000, 18, 1'b0, S + P + 10);
      chk("run_high", run, 1);

      // run never falls: timeout.
      run_cmd(OP_STOP, 12'h000, 2 + 2*S + P + T, 1'b1, 0);

      // run already at target: a single WAIT_RUN cycle.
      run_cmd(OP_START, 12'h000, 2 + 2*S + P, 1'b0, 0);

      // Reset in the middle of a DEP pulse.
      cmd_op    = OP_DEP;
      cmd_data  = 12'h3C3;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      repeat (5) step();
      chk("mid_dep_sw_high", dep_sw, 1);
      rst = 1'b0;
      #1;
      exp_sw = 12'h000;
      chk("mid_rst_dep_sw", dep_sw, 0);
      chk("mid_rst_sw", sw, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_resp", resp_valid, 0);
      step();
      step();
      rst = 1'b1;
      nresp = 0;
      for (int i = 0; i < 15; i++) begin
         if (resp_valid) nresp++;
         step();
      end
      chk("no_resp_after_rst", nresp, 0);
      run_cmd(OP_DEP, 12'h0F1, 1 + 2*S + P, 1'b0, 0);

      // cmd_valid held high across two back-to-back INCPs.
      cmd_op    = OP_INCP;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 2 + 2*(1 + 2*S + P); i++) begin
         if (cmd_ready) begin
            acc++;
            push_resp(1'b0, cyc + 1 + 2*S + P);
         end
         step();
      end
      cmd_valid = 1'b0;
      chk("held_accepts", acc, 2);
      chk("held_sw_kept", sw, 12'h0F1);
      repeat (3) step();
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
